// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bus: pipeline register indices/status in, stall/flush/forward controls out.
// master = pipeline datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] rs1D;
  logic [REG_W-1:0] rs2D;
  logic [REG_W-1:0] rs1E;
  logic [REG_W-1:0] rs2E;
  logic [REG_W-1:0] rdE;
  logic             memReadE;
  logic [REG_W-1:0] rdM;
  logic             regWriteM;
  logic [REG_W-1:0] rdW;
  logic             regWriteW;
  logic             branchTakenE;
  logic             mdStartE;
  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             flushD;
  logic             flushE;
  logic             flushM;
  logic [1:0]       fwdAE;
  logic [1:0]       fwdBE;
  logic             mdBusy;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, memReadE, rdM, regWriteM,
           rdW, regWriteW, branchTakenE, mdStartE,
    input  stallF, stallD, stallE, flushD, flushE, flushM, fwdAE, fwdBE, mdBusy
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, memReadE, rdM, regWriteM,
           rdW, regWriteW, branchTakenE, mdStartE,
    output stallF, stallD, stallE, flushD, flushE, flushM, fwdAE, fwdBE, mdBusy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, load-use, branch flush, mul/div hold FSM.
// Optional HAZARD_PERF_EN adds stallCount/flushCount performance counters.
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MD_LATENCY = 4
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   stallCount,
  output logic [31:0]   flushCount
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  // First cycle in E is spent in IDLE, last one in BUSY with cnt==0.
  localparam logic [3:0] MD_RELOAD = 4'(MD_LATENCY - 2);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       md_stall;
  logic       lu;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rd_m,
    input logic             we_m,
    input logic [REG_W-1:0] rd_w,
    input logic             we_w
  );
    if (we_m && (rd_m != '0) && (rd_m == rs))      return 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (hz.mdStartE) begin
          md_stall = 1'b1;
          state_d  = BUSY;
          cnt_d    = MD_RELOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign lu = hz.memReadE && (hz.rdE != '0) &&
              ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  // Output decode: md hold beats branch redirect beats load-use; reset forces everything quiet.
  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    hz.flushM = 1'b0;
    hz.fwdAE  = 2'b00;
    hz.fwdBE  = 2'b00;
    hz.mdBusy = 1'b0;
    if (!reset) begin
      hz.fwdAE  = fwd_sel(hz.rs1E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
      hz.fwdBE  = fwd_sel(hz.rs2E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
      hz.mdBusy = (state_q == BUSY);
      if (md_stall) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.flushM = 1'b1;
      end else if (hz.branchTakenE) begin
        hz.flushD = 1'b1;
        hz.flushE = 1'b1;
      end else if (lu) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.flushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (reset) begin
      stall_count_d = 32'd0;
      flush_count_d = 32'd0;
    end else begin
      if (hz.stallF)                            stall_count_d = stall_count_q + 32'd1;
      if (hz.flushD || hz.flushE || hz.flushM)  flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    stall_count_q <= stall_count_d;
    flush_count_q <= flush_count_d;
  end

  assign stallCount = stall_count_q;
  assign flushCount = flush_count_q;
`endif

endmodule
